// File: rtl/kme_clk_gate_pkg.sv
// kme_clk_gate_pkg: shared types and defaults for the kme clock-gate controller
// Holds the FSM state enum, default idle/wake cycle counts and the countdown width.
package kme_clk_gate_pkg;
  typedef enum logic [1:0] {RUN, IDLE_WAIT, GATED, WAKE} state_t;
  localparam int DEF_IDLE_CYCLES = 16;
  localparam int DEF_WAKE_CYCLES = 4;
  localparam int CNT_W = 8;
endpackage

// File: rtl/kme_clk_gate_cnt.sv
// kme_clk_gate_cnt: loadable down-counter with zero flag, stops at 0
// Ports: clk, rst_n (async active-low), load/load_val (reload), dec (count down), zero (count is 0).
module kme_clk_gate_cnt
  import kme_clk_gate_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/kme_clk_gate_ctrl.sv
// kme_clk_gate_ctrl: idle-driven clock gating controller for the kme_tb_dut domain
// Ports: clk, rst_n (async active-low), gate_req (gating permitted), ungate_req (force wake),
// dut_idle (no pending work), clk_en (gate cell enable), gate_ack (high while GATED),
// wake_done (pulse on WAKE->RUN), gate_cnt (saturating count of gate entries).
module kme_clk_gate_ctrl
  import kme_clk_gate_pkg::*;
#(
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gate_req,
  input  logic        ungate_req,
  input  logic        dut_idle,
  output logic        clk_en,
  output logic        gate_ack,
  output logic        wake_done,
  output logic [15:0] gate_cnt
);
  if (IDLE_CYCLES < 1 || IDLE_CYCLES > 255) begin : g_bad_idle
    $error("IDLE_CYCLES must be in 1..255");
  end
  if (WAKE_CYCLES < 1 || WAKE_CYCLES > 255) begin : g_bad_wake
    $error("WAKE_CYCLES must be in 1..255");
  end
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  state_t state, nxt;
  logic cnt_zero, cnt_load, cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  // Any of these leaves (or blocks entry to) the gated path; ungate_req thus wins everywhere.
  logic cause;
  assign cause = ungate_req || !gate_req || !dut_idle;
  always_comb begin
    nxt = state;
    cnt_load = 1'b0;
    cnt_val = '0;
    cnt_dec = 1'b0;
    case (state)
      RUN: begin
        nxt = cause ? RUN : IDLE_WAIT;
        cnt_load = !cause;
        cnt_val = IDLE_LOAD;
      end
      IDLE_WAIT: begin
        nxt = cause ? RUN : cnt_zero ? GATED : IDLE_WAIT;
        cnt_dec = !cause && !cnt_zero;
      end
      GATED: begin
        nxt = cause ? WAKE : GATED;
        cnt_load = cause;
        cnt_val = WAKE_LOAD;
      end
      WAKE: begin
        nxt = cnt_zero ? RUN : WAKE;
        cnt_dec = !cnt_zero;
      end
      default: nxt = RUN;
    endcase
  end
  kme_clk_gate_cnt u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .load(cnt_load),
    .load_val(cnt_val),
    .dec(cnt_dec),
    .zero(cnt_zero)
  );
  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      clk_en <= 1'b1;
      gate_ack <= 1'b0;
      wake_done <= 1'b0;
      gate_cnt <= '0;
    end else begin
      state <= nxt;
      clk_en <= nxt != GATED;
      gate_ack <= nxt == GATED;
      wake_done <= state == WAKE && nxt == RUN;
      if (state == IDLE_WAIT && nxt == GATED && gate_cnt != 16'hFFFF) gate_cnt <= gate_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_kme_clk_gate_ctrl.sv
// tb_kme_clk_gate_ctrl: self-checking bench for kme_clk_gate_ctrl with a streak/timer reference model
module tb_kme_clk_gate_ctrl;
  localparam int IDLE = 16;
  localparam int WAKE = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic gate = 1'b0, ungate = 1'b0, idle = 1'b0;
  logic clk_en, gate_ack, wake_done;
  logic [15:0] gate_cnt;
  logic gs = 1'b0, us = 1'b0, is = 1'b0;
  logic s_clk_en, s_gate_ack, s_wake_done;
  logic [15:0] s_gate_cnt;
  int checks = 0, errors = 0;
  bit m_gated, m_wd;
  int m_streak, m_wake;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  kme_clk_gate_ctrl dut (
    .clk(clk), .rst_n(rst_n), .gate_req(gate), .ungate_req(ungate), .dut_idle(idle),
    .clk_en(clk_en), .gate_ack(gate_ack), .wake_done(wake_done), .gate_cnt(gate_cnt)
  );
  kme_clk_gate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .gate_req(gs), .ungate_req(us), .dut_idle(is),
    .clk_en(s_clk_en), .gate_ack(s_gate_ack), .wake_done(s_wake_done), .gate_cnt(s_gate_cnt)
  );

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_gated = 0; m_wd = 0; m_streak = 0; m_wake = 0; m_cnt = '0;
  endtask

  // Model: gating happens once IDLE+1 consecutive qualifying samples are seen outside a wake;
  // a wake lasts WAKE edges and ignores inputs.
  task automatic step();
    @(posedge clk);
    m_wd = 0;
    if (m_wake > 0) begin
      m_wake--;
      if (m_wake == 0) m_wd = 1;
    end else if (m_gated) begin
      if (ungate || !gate || !idle) begin m_gated = 0; m_wake = WAKE; end
    end else begin
      m_streak = (gate && idle && !ungate) ? m_streak + 1 : 0;
      if (m_streak == IDLE + 1) begin
        m_gated = 1; m_streak = 0;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL reset_clk_en: got %b expected 1", clk_en); end
    checks++; if (gate_ack !== 1'b0) begin errors++; $display("FAIL reset_gate_ack: got %b expected 0", gate_ack); end
    checks++; if (wake_done !== 1'b0) begin errors++; $display("FAIL reset_wake_done: got %b expected 0", wake_done); end
    checks++; if (gate_cnt !== 16'd0) begin errors++; $display("FAIL reset_gate_cnt: got %h expected 0000", gate_cnt); end
  endtask

  task automatic test_gate_latency();
    bit early = 0;
    gate = 1; idle = 1; ungate = 0; model_reset(); rst_n = 1'b1;
    for (int i = 0; i < IDLE; i++) begin step(); if (clk_en !== 1'b1) early = 1; end
    checks++; if (early) begin errors++; $display("FAIL latency_early: clk_en low before edge %0d, expected high", IDLE + 1); end
    step();
    checks++; if (clk_en !== 1'b0) begin errors++; $display("FAIL latency_clk_en: got %b expected 0", clk_en); end
    checks++; if (gate_ack !== 1'b1) begin errors++; $display("FAIL latency_gate_ack: got %b expected 1", gate_ack); end
    checks++; if (gate_cnt !== 16'd1) begin errors++; $display("FAIL latency_gate_cnt: got %0d expected 1", gate_cnt); end
    checks++; if (gate_ack !== m_gated) begin errors++; $display("FAIL latency_model: got %b expected %b", gate_ack, m_gated); end
  endtask

  task automatic test_wake();
    bit early = 0;
    ungate = 1; step(); ungate = 0;
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL wake_clk_en: got %b expected 1", clk_en); end
    checks++; if (gate_ack !== 1'b0) begin errors++; $display("FAIL wake_gate_ack: got %b expected 0", gate_ack); end
    for (int i = 0; i < WAKE - 1; i++) begin step(); if (wake_done !== 1'b0) early = 1; end
    checks++; if (early) begin errors++; $display("FAIL wake_early: wake_done high before edge %0d, expected low", WAKE); end
    gate = 0;
    step();
    checks++; if (wake_done !== 1'b1) begin errors++; $display("FAIL wake_done_pulse: got %b expected 1", wake_done); end
    checks++; if (gate_cnt !== 16'd1) begin errors++; $display("FAIL wake_gate_cnt: got %0d expected 1", gate_cnt); end
    step();
    checks++; if (wake_done !== 1'b0) begin errors++; $display("FAIL wake_done_width: got %b expected 0", wake_done); end
  endtask

  task automatic test_abort();
    bit low = 0;
    gate = 1; idle = 1;
    for (int i = 0; i < 10; i++) begin step(); if (clk_en !== 1'b1) low = 1; end
    idle = 0;
    for (int i = 0; i < 20; i++) begin step(); if (clk_en !== 1'b1) low = 1; end
    checks++; if (low) begin errors++; $display("FAIL abort_clk_en: clk_en went low, expected always high"); end
    checks++; if (gate_cnt !== 16'd1) begin errors++; $display("FAIL abort_gate_cnt: got %0d expected 1", gate_cnt); end
    idle = 1;
    for (int i = 0; i < 16; i++) step();
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL abort_restart: got %b expected 1 after 16 edges", clk_en); end
    gate = 0; step();
  endtask

  task automatic test_ungate_priority();
    bit bad = 0;
    gate = 1; idle = 1; ungate = 1;
    for (int i = 0; i < 40; i++) begin step(); if (clk_en !== 1'b1 || gate_ack !== 1'b0) bad = 1; end
    checks++; if (bad) begin errors++; $display("FAIL ungate_priority: clk_en/gate_ack changed, expected 1/0"); end
    ungate = 0; gate = 0; step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      gate = $urandom_range(0, 15) != 0;
      idle = $urandom_range(0, 24) != 0;
      ungate = $urandom_range(0, 39) == 0;
      step();
      checks++;
      if (clk_en !== !m_gated || gate_ack !== m_gated || wake_done !== m_wd || gate_cnt !== m_cnt) begin
        errors++;
        $display("FAIL random[%0d]: got en=%b ack=%b wd=%b cnt=%0d expected en=%b ack=%b wd=%b cnt=%0d",
                 i, clk_en, gate_ack, wake_done, gate_cnt, !m_gated, m_gated, m_wd, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_gated();
    int n = 0;
    gate = 1; idle = 1; ungate = 0;
    while (!m_gated && n < 60) begin step(); n++; end
    checks++; if (gate_ack !== 1'b1) begin errors++; $display("FAIL pre_reset_gated: got %b expected 1", gate_ack); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (clk_en !== 1'b1) begin errors++; $display("FAIL async_reset_clk_en: got %b expected 1", clk_en); end
    checks++; if (gate_ack !== 1'b0) begin errors++; $display("FAIL async_reset_gate_ack: got %b expected 0", gate_ack); end
    checks++; if (gate_cnt !== 16'd0) begin errors++; $display("FAIL async_reset_gate_cnt: got %0d expected 0", gate_cnt); end
    gate = 0;
    @(posedge clk); #1;
    model_reset(); rst_n = 1'b1;
  endtask

  task automatic one_gate_event();
    @(negedge clk); us = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); us = 1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_saturation();
    gs = 1; is = 1;
    for (int i = 0; i < 65534; i++) one_gate_event();
    #1;
    checks++; if (s_gate_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h expected fffe", s_gate_cnt); end
    one_gate_event();
    #1;
    checks++; if (s_gate_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h expected ffff", s_gate_cnt); end
    @(negedge clk); us = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_gate_ack !== 1'b1) begin errors++; $display("FAIL sat_gated: got %b expected 1", s_gate_ack); end
    checks++; if (s_gate_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", s_gate_cnt); end
  endtask

  initial begin
    test_reset();
    test_gate_latency();
    test_wake();
    test_abort();
    test_ungate_priority();
    test_random();
    test_reset_mid_gated();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
